// File: rtl/evt_window_sched_if.sv
// rtl/evt_window_sched_if.sv - result handshake bundle for evt_window_sched
interface evt_window_sched_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    localparam int CH_W = $clog2(N_CH);

    logic             result_valid_out;
    logic             result_ready_in;
    logic [CNT_W-1:0] result_count_out;
    logic [CH_W-1:0]  result_ch_out;
    logic             result_sat_out;

    modport master (
        output result_valid_out, result_count_out, result_ch_out, result_sat_out,
        input  result_ready_in
    );

    modport slave (
        input  result_valid_out, result_count_out, result_ch_out, result_sat_out,
        output result_ready_in
    );
endinterface

// File: rtl/evt_window_sched.sv
// rtl/evt_window_sched.sv - time-multiplexed windowed event counter over N channels
// Optional EVT_WINDOW_EDGE_EN: count rising edges of the selected strobe instead of high cycles.
module evt_window_sched #(
    parameter int N_CH  = 4,
    parameter int WIN_W = 20,
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic             stop_in,
    input  logic             continuous_in,
    input  logic [WIN_W-1:0] window_len_in,
    input  logic [N_CH-1:0]  ch_mask_in,
    input  logic [N_CH-1:0]  evt_in,
    evt_window_sched_if.master res_if,
    output logic             busy_out,
    output logic             sweep_done_out
);
    localparam int CH_W = $clog2(N_CH);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_COUNT, S_REPORT} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [N_CH-1:0]  r_mask;
    logic             r_cont;
    logic [WIN_W-1:0] r_len;
    logic [WIN_W-1:0] r_timer;
    logic [CH_W-1:0]  r_ptr;
    logic [CNT_W-1:0] r_acc;
    logic             r_sat;
    logic             r_busy;
    logic             r_done;
    logic [N_CH-1:0]  w_above;
    logic             w_hs;
    logic             w_hit;

    function automatic logic [CH_W-1:0] lowest(input logic [N_CH-1:0] m);
        lowest = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) lowest = CH_W'(i);
        end
    endfunction

    always_comb begin
        w_above = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_above[i] = r_mask[i] && (CH_W'(i) > r_ptr);
        end
    end

`ifdef EVT_WINDOW_EDGE_EN
    logic [N_CH-1:0] r_prev;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_prev <= '0;
        else           r_prev <= evt_in;
    end

    assign w_hit = evt_in[r_ptr] & ~r_prev[r_ptr];
`else
    assign w_hit = evt_in[r_ptr];
`endif

    assign w_hs = (r_state == S_REPORT) && res_if.result_ready_in;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start_in && (|ch_mask_in)) w_next_state = S_SELECT;
            S_SELECT: w_next_state = S_COUNT;
            S_COUNT:  if (r_timer == '0) w_next_state = S_REPORT;
            S_REPORT: begin
                if (w_hs) begin
                    if ((|w_above) || r_cont) w_next_state = S_SELECT;
                    else                      w_next_state = S_IDLE;
                end
            end
            default:  w_next_state = S_IDLE;
        endcase
        if (stop_in) w_next_state = S_IDLE;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_cont  <= 1'b0;
            r_len   <= '0;
            r_timer <= '0;
            r_ptr   <= '0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            r_done  <= 1'b0;
            if (!stop_in) begin
                case (r_state)
                    S_IDLE: begin
                        if (start_in && (|ch_mask_in)) begin
                            r_mask <= ch_mask_in;
                            r_cont <= continuous_in;
                            r_len  <= (window_len_in == '0) ? WIN_W'(1) : window_len_in;
                            r_ptr  <= lowest(ch_mask_in);
                        end
                    end
                    S_SELECT: begin
                        r_acc   <= '0;
                        r_sat   <= 1'b0;
                        r_timer <= r_len - WIN_W'(1);
                    end
                    S_COUNT: begin
                        if (r_timer != '0) r_timer <= r_timer - WIN_W'(1);
                        // At full scale the count freezes and the saturation flag latches.
                        if (r_acc == '1) r_sat <= 1'b1;
                        else             r_acc <= r_acc + CNT_W'(w_hit);
                    end
                    S_REPORT: begin
                        if (w_hs) begin
                            if (|w_above) begin
                                r_ptr <= lowest(w_above);
                            end else begin
                                r_ptr  <= lowest(r_mask);
                                r_done <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign res_if.result_valid_out = (r_state == S_REPORT);
    assign res_if.result_count_out = r_acc;
    assign res_if.result_ch_out    = r_ptr;
    assign res_if.result_sat_out   = r_sat;
    assign busy_out                = r_busy;
    assign sweep_done_out          = r_done;
endmodule

// File: tb/tb_evt_window_sched.sv
// tb/tb_evt_window_sched.sv - scoreboard bench for evt_window_sched
module tb_evt_window_sched;
    localparam int N_CH  = 4;
    localparam int WIN_W = 20;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] cnt;
        logic       sat;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             cont = 1'b0;
    logic [WIN_W-1:0] len = '0;
    logic [N_CH-1:0]  mask = '0;
    logic [N_CH-1:0]  evt = '0;
    logic             busy;
    logic             done;

    evt_window_sched_if #(.N_CH(N_CH), .CNT_W(CNT_W)) res ();

    evt_window_sched #(.N_CH(N_CH), .WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .start_in       (start),
        .stop_in        (stop),
        .continuous_in  (cont),
        .window_len_in  (len),
        .ch_mask_in     (mask),
        .evt_in         (evt),
        .res_if         (res),
        .busy_out       (busy),
        .sweep_done_out (done)
    );

    always #5 clk = ~clk;

    res_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   valid_seen = 0;
    int   g_stall = 0;
    int   stall = 0;
    bit   hs_pending = 0;
    bit   holding = 0;
    res_t held;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial res.result_ready_in = 1'b0;

    // Monitor: owns ready, checks stability under stall, pops scoreboard at handshake.
    always @(negedge clk) begin
        res_t cur;
        res_t exp;
        cur = '{res.result_ch_out, res.result_count_out, res.result_sat_out};
        if (done) done_cnt++;
        if (hs_pending) begin
            res.result_ready_in = 1'b0;
            hs_pending = 0;
        end
        if (!res.result_valid_out) begin
            holding = 0;
            stall = 0;
        end else begin
            valid_seen++;
            if (holding) check("stable_while_stalled", int'(cur), int'(held));
            else begin
                holding = 1;
                held = cur;
            end
            if (stall >= g_stall) begin
                res.result_ready_in = 1'b1;
                hs_pending = 1;
                holding = 0;
                stall = 0;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %0d expected none", int'(cur));
                end else begin
                    exp = sb.pop_front();
                    check("result {ch,cnt,sat}", int'(cur), int'(exp));
                end
            end else begin
                stall++;
            end
        end
    end

    task automatic kick(input logic [3:0] m, input int l, input logic c);
        @(negedge clk);
        mask = m;
        len = WIN_W'(l);
        cont = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int idx0, output int n);
        n = idx0;
        while (!res.result_valid_out && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!res.result_valid_out) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle_timeout: got busy=1 expected 0");
        end
    endtask

    initial begin
        int n;
        int d0;
        int v0;
        int k;

        @(negedge clk);
        check("reset_valid", res.result_valid_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_count", res.result_count_out, 0);
        check("reset_ch", res.result_ch_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef EVT_WINDOW_EDGE_EN
        evt = 4'b0001;
        sb.push_back('{2'd0, 4'd3, 1'b0});
        kick(4'b0001, 16, 1'b0);
        repeat (4) @(negedge clk); evt[0] = 1'b0;
        @(negedge clk);            evt[0] = 1'b1;
        repeat (2) @(negedge clk); evt[0] = 1'b0;
        @(negedge clk);            evt[0] = 1'b1;
        repeat (2) @(negedge clk); evt[0] = 1'b0;
        @(negedge clk);            evt[0] = 1'b1;
        wait_valid(12, n);
        check("edge_latency", n, 18);
        wait_idle(50);
        repeat (3) @(negedge clk);
        check("edge_sb_empty", sb.size(), 0);
`else
        // Single channel, neighbours active but ignored.
        evt = 4'b1010;
        d0 = done_cnt;
        sb.push_back('{2'd2, 4'd7, 1'b0});
        kick(4'b0100, 10, 1'b0);
        repeat (3) @(negedge clk); evt[2] = 1'b1;
        repeat (7) @(negedge clk); evt[2] = 1'b0;
        wait_valid(11, n);
        check("t1_latency", n, 12);
        wait_idle(50);
        repeat (3) @(negedge clk);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_busy", busy, 0);

        // Multi-channel sweep with backpressure.
        g_stall = 5;
        evt = 4'b1111;
        d0 = done_cnt;
        sb.push_back('{2'd0, 4'd4, 1'b0});
        sb.push_back('{2'd1, 4'd4, 1'b0});
        sb.push_back('{2'd3, 4'd4, 1'b0});
        kick(4'b1011, 4, 1'b0);
        wait_idle(300);
        repeat (3) @(negedge clk);
        check("t2_done_pulses", done_cnt - d0, 1);
        check("t2_sb_empty", sb.size(), 0);
        g_stall = 0;

        // Saturation, then a quiet window clears it.
        sb.push_back('{2'd0, 4'd15, 1'b1});
        kick(4'b0001, 20, 1'b0);
        wait_idle(100);
        evt = 4'b0000;
        sb.push_back('{2'd0, 4'd0, 1'b0});
        kick(4'b0001, 20, 1'b0);
        wait_idle(100);
        repeat (3) @(negedge clk);
        check("t3_sb_empty", sb.size(), 0);

        // Zero-length window is one cycle.
        evt = 4'b1111;
        sb.push_back('{2'd0, 4'd1, 1'b0});
        kick(4'b0001, 0, 1'b0);
        wait_valid(1, n);
        check("t4_len0_latency", n, 3);
        wait_idle(50);

        // Empty mask and start-with-stop are both ignored.
        repeat (3) @(negedge clk);
        v0 = valid_seen;
        kick(4'b0000, 5, 1'b0);
        check("t4_empty_mask_busy", busy, 0);
        stop = 1'b1;
        kick(4'b0001, 5, 1'b0);
        stop = 1'b0;
        check("t4_stop_start_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("t4_no_valid", valid_seen - v0, 0);

        // Continuous: two full sweeps, then stop mid-COUNT.
        evt = 4'b0000;
        d0 = done_cnt;
        sb.push_back('{2'd0, 4'd0, 1'b0});
        sb.push_back('{2'd1, 4'd0, 1'b0});
        sb.push_back('{2'd0, 4'd0, 1'b0});
        sb.push_back('{2'd1, 4'd0, 1'b0});
        kick(4'b0011, 3, 1'b1);
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (sb.size() != 0 && k < 200);
        check("t5_sweeps_consumed", sb.size(), 0);
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t5_stop_busy", busy, 0);
        check("t5_stop_valid", res.result_valid_out, 0);
        v0 = valid_seen;
        repeat (10) @(negedge clk);
        check("t5_done_pulses", done_cnt - d0, 2);
        check("t5_no_valid_after_stop", valid_seen - v0, 0);

        // Async reset while a result is stalled in REPORT.
        g_stall = 1000;
        evt = 4'b0001;
        kick(4'b0001, 2, 1'b0);
        wait_valid(1, n);
        check("t6_count_before_reset", res.result_count_out, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", res.result_valid_out, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_count", res.result_count_out, 0);
        check("t6_rst_ch", res.result_ch_out, 0);
        check("t6_rst_sat", res.result_sat_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        g_stall = 0;
        repeat (3) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
